// File: rtl/alu_shift_issue_queue_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg: shared opcode constants and request type for shift issue  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SAR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [3:0]           opcode;
    logic                 illegal;
  } alu_shift_req_t;

  function automatic logic is_shift_op(input logic [3:0] opcode);
    return (opcode == OP_SLL) || (opcode == OP_SAR) ||
           (opcode == OP_ROL) || (opcode == OP_ROR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shift_issue_queue_fifo.sv
// +--------------------------------------------------------------------+
// | alu_sync_fifo: generic synchronous FIFO with fall-through head     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  T                         wdata_i,
  input  logic                     pop_i,
  output T                         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/alu_shift_issue_queue.sv
// +--------------------------------------------------------------------+
// | alu_shift_issue_queue: sanitising issue buffer for the shift ALU   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_shift_issue_queue
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int SHAMT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic [3:0]              in_opcode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_a,
  output logic [WIDTH-1:0]        out_b,
  output logic [3:0]              out_opcode,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count,
  output logic [7:0]              illegal_cnt
);

  alu_shift_req_t in_req, head;
  logic           legal, push, pop, full, empty;
  logic [7:0]     illegal_cnt_q;
  logic           unused_b_hi;

  assign legal          = is_shift_op(in_opcode);
  assign in_req.a       = in_a;
  assign in_req.b       = {{(WIDTH-SHAMT_W){1'b0}}, in_b[SHAMT_W-1:0]};
  assign in_req.opcode  = legal ? in_opcode : OP_NOP;
  assign in_req.illegal = !legal;
  assign unused_b_hi    = ^in_b[WIDTH-1:SHAMT_W];

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_sync_fifo #(
    .T     (alu_shift_req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (in_req),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Data outputs are held at zero while the queue is empty.
  assign out_a       = out_valid ? head.a       : '0;
  assign out_b       = out_valid ? head.b       : '0;
  assign out_opcode  = out_valid ? head.opcode  : OP_NOP;
  assign out_illegal = out_valid ? head.illegal : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (!flush && push && !legal && illegal_cnt_q != 8'hFF) begin
      illegal_cnt_q <= illegal_cnt_q + 8'd1;
    end
  end

  assign illegal_cnt = illegal_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_issue_queue.sv
// +--------------------------------------------------------------------+
// | tb_alu_shift_issue_queue: directed self-checking bench             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_shift_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_opcode;
  logic        in_ready, out_valid, out_illegal;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_opcode;
  logic [2:0]  count;
  logic [7:0]  illegal_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_shift_issue_queue #(.WIDTH(16), .DEPTH(4), .SHAMT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_opcode   (in_opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_opcode  (out_opcode),
    .out_illegal (out_illegal),
    .count       (count),
    .illegal_cnt (illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    in_valid = v; in_a = a; in_b = b; in_opcode = op;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("rst_count",     {29'b0, count}, 32'd0);
    chk("rst_out_a",     {16'b0, out_a}, 32'd0);
    chk("rst_out_b",     {16'b0, out_b}, 32'd0);
    chk("rst_out_op",    {28'b0, out_opcode}, 32'd0);
    chk("rst_out_ill",   {31'b0, out_illegal}, 32'd0);
    chk("rst_ill_cnt",   {24'b0, illegal_cnt}, 32'd0);

    // Single push, one-cycle latency, amount reduced mod 16.
    drive(1'b1, 16'h8001, 16'h0011, 4'd5);
    chk("no_bypass", {31'b0, out_valid}, 32'd0);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    chk("p1_valid", {31'b0, out_valid}, 32'd1);
    chk("p1_a",     {16'b0, out_a}, 32'h8001);
    chk("p1_b",     {16'b0, out_b}, 32'h0001);
    chk("p1_op",    {28'b0, out_opcode}, 32'd5);
    chk("p1_ill",   {31'b0, out_illegal}, 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("p1_drained", {29'b0, count}, 32'd0);
    chk("p1_gate_a",  {16'b0, out_a}, 32'd0);

    // Fill to full with consumer stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 16'h0010 + 16'(i), 4'(5 + i));
      step();
    end
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 16'hDEAD, 16'h0, 4'd5);
    step();
    chk("fifth_push", {29'b0, count}, 32'd4);
    // Pop while full: the offered push must still be refused.
    chk("drain0_a", {16'b0, out_a}, 32'h0100);
    out_ready = 1'b1;
    step();
    chk("full_pop_push", {29'b0, count}, 32'd3);
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("drain_a",  {16'b0, out_a}, 32'h0100 + i);
      chk("drain_b",  {16'b0, out_b}, i);
      chk("drain_op", {28'b0, out_opcode}, 5 + i);
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    chk("drain_empty", {29'b0, count}, 32'd0);

    // Streaming: one in, one out per cycle.
    out_ready = 1'b1;
    drive(1'b1, 16'h0, 16'h0003, 4'd7);
    step();
    for (int k = 1; k <= 20; k++) begin
      in_a = 16'(k);
      step();
      chk("stream_count", {29'b0, count}, 32'd1);
      chk("stream_a",     {16'b0, out_a}, k);
    end
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    step();
    chk("stream_end", {29'b0, count}, 32'd0);
    out_ready = 1'b0;

    // Illegal opcode handling and counter saturation.
    drive(1'b1, 16'h1234, 16'h0002, 4'd3);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    chk("ill_op",  {28'b0, out_opcode}, 32'd0);
    chk("ill_flag",{31'b0, out_illegal}, 32'd1);
    chk("ill_a",   {16'b0, out_a}, 32'h1234);
    chk("ill_cnt1",{24'b0, illegal_cnt}, 32'd1);
    out_ready = 1'b1; step();
    drive(1'b1, 16'h0, 16'h0, 4'd3);
    for (int k = 0; k < 300; k++) step();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    chk("ill_sat", {24'b0, illegal_cnt}, 32'd255);
    step();
    out_ready = 1'b0;
    chk("ill_drained", {29'b0, count}, 32'd0);

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h00A0 + 16'(i), 16'h0, 4'd6);
      step();
    end
    chk("pre_flush", {29'b0, count}, 32'd3);
    flush = 1'b1;
    drive(1'b1, 16'hBEEF, 16'h0, 4'd3);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ill",   {24'b0, illegal_cnt}, 32'd255);
    drive(1'b1, 16'h5555, 16'h0, 4'd8);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    chk("post_flush_a", {16'b0, out_a}, 32'h5555);
    chk("post_flush_n", {29'b0, count}, 32'd1);

    // Reset during traffic with two entries queued.
    drive(1'b1, 16'h6666, 16'h0, 4'd5);
    step();
    chk("pre_rst", {29'b0, count}, 32'd2);
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b1, 16'h7777, 16'h0, 4'd2);
    step();
    chk("rst_mid_count", {29'b0, count}, 32'd0);
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_ill",   {24'b0, illegal_cnt}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b0;

    // Illegal push during flush must not count.
    flush = 1'b1;
    drive(1'b1, 16'h1111, 16'h0, 4'd9);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    chk("flush_no_inc", {24'b0, illegal_cnt}, 32'd0);
    chk("flush_no_push", {29'b0, count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
